// File: rtl/mux_nto1_pipe.sv
// N-input select-and-register stage with valid/ready handshake and a 2-entry skid buffer.
// Optional feature macro: MUX_SEL_ERR_EN adds a sticky sel_err output for out-of-range selects.
module mux_nto1_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 8,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_SEL_ERR_EN
    ,
    output logic               sel_err
`endif
);

    // State encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] sel_data_c;
    logic             accept_c;
    logic             pop_c;

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_data_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                sel_data_c = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = rst_n & ~state_q[0];
    assign out_valid = state_q[1];
    assign out_data  = main_q;
    assign accept_c  = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d = ST_ONE;
                        main_d  = sel_data_c;
                    end
                end
                ST_ONE: begin
                    if (accept_c && pop_c) begin
                        main_d = sel_data_c;
                    end else if (accept_c) begin
                        state_d = ST_FULL;
                        skid_d  = sel_data_c;
                    end else if (pop_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_c) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

`ifdef MUX_SEL_ERR_EN
    logic sel_err_q, sel_err_d;
    logic sel_oob_c;

    always_comb begin
        sel_oob_c = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                sel_oob_c = 1'b0;
            end
        end
    end

    // Sticky until reset; flush leaves it alone.
    assign sel_err_d = sel_err_q | (accept_c & sel_oob_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: directed vectors plus a randomized stream on an N=8 instance,
// and out-of-range select checks on an N=5 instance.
module tb_mux_nto1_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned N8 = 8;
    localparam int unsigned N5 = 5;

    logic              clk;
    logic              rst_n;

    logic [N8*W-1:0]   in_bus;
    logic [2:0]        sel;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;

    logic [N5*W-1:0]   in_bus5;
    logic [2:0]        sel5;
    logic              in_valid5;
    logic              in_ready5;
    logic              flush5;
    logic [W-1:0]      out_data5;
    logic              out_valid5;
    logic              out_ready5;
`ifdef MUX_SEL_ERR_EN
    logic              sel_err8;
    logic              sel_err5;
`endif

    logic [W-1:0]      exp_cur;
    logic [W-1:0]      sb[$];
    logic              stall_prev;
    logic [W-1:0]      held_data;
    int                n_tests;
    int                n_fail;

    mux_nto1_pipe #(.WIDTH(W), .N(N8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bus    (in_bus),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err8)
`endif
    );

    mux_nto1_pipe #(.WIDTH(W), .N(N5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bus    (in_bus5),
        .sel       (sel5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .flush     (flush5),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [2:0] s, input logic [W-1:0] e);
        in_valid = v;
        sel      = s;
        exp_cur  = e;
    endtask

    // Monitor: inputs settle at posedge+1, so the negedge sees exactly what the next edge will use.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, held_data);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", out_data, 32'hDEAD_BEEF);
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_pop: got an output with empty scoreboard at %0t", $time);
                    end else begin
                        chk("sb_data", out_data, sb.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(exp_cur);
                end
            end
            stall_prev = out_valid && !out_ready && !flush;
            held_data  = out_data;
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        stall_prev = 1'b0;
        held_data  = '0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        for (int k = 0; k < int'(N8); k++) in_bus[k*W +: W] = 32'h1000_0000 + 32'(k);
        beat(1'b1, 3'd3, 32'h1000_0003);
        in_bus5    = '0;
        for (int k = 0; k < int'(N5); k++) in_bus5[k*W +: W] = 32'h5000_0000 + 32'(k);
        sel5       = 3'd0;
        in_valid5  = 1'b0;
        flush5     = 1'b0;
        out_ready5 = 1'b1;

        // 1) reset held for two cycles with in_valid high
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
        end
        rst_n = 1'b1;
        beat(1'b0, 3'd0, 32'h0);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
`ifdef MUX_SEL_ERR_EN
        chk("rst_sel_err5", 32'(sel_err5), 32'd0);
`endif

        // 2) streaming at full rate
        beat(1'b1, 3'd3, 32'h1000_0003); tick();
        chk("str0_data", out_data, 32'h1000_0003);
        chk("str0_valid", 32'(out_valid), 32'd1);
        beat(1'b1, 3'd7, 32'h1000_0007); tick();
        chk("str1_data", out_data, 32'h1000_0007);
        chk("str1_valid", 32'(out_valid), 32'd1);
        beat(1'b1, 3'd0, 32'h1000_0000); tick();
        chk("str2_data", out_data, 32'h1000_0000);
        chk("str2_valid", 32'(out_valid), 32'd1);
        beat(1'b0, 3'd0, 32'h0); tick();
        chk("str_idle_valid", 32'(out_valid), 32'd0);

        // 3) stall into the skid buffer, then drain
        out_ready = 1'b0;
        beat(1'b1, 3'd1, 32'h1000_0001); tick();
        chk("stl_one_data", out_data, 32'h1000_0001);
        chk("stl_one_ready", 32'(in_ready), 32'd1);
        beat(1'b1, 3'd2, 32'h1000_0002); tick();
        chk("stl_full_data", out_data, 32'h1000_0001);
        chk("stl_full_ready", 32'(in_ready), 32'd0);
        beat(1'b1, 3'd5, 32'h1000_0005); tick();
        chk("stl_hold_data", out_data, 32'h1000_0001);
        chk("stl_hold_ready", 32'(in_ready), 32'd0);
        beat(1'b0, 3'd0, 32'h0);
        out_ready = 1'b1; tick();
        chk("drn1_data", out_data, 32'h1000_0002);
        chk("drn1_valid", 32'(out_valid), 32'd1);
        chk("drn1_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drn2_valid", 32'(out_valid), 32'd0);

        // 4) flush while FULL with a beat presented, then flush while EMPTY
        out_ready = 1'b0;
        beat(1'b1, 3'd4, 32'h1000_0004); tick();
        beat(1'b1, 3'd6, 32'h1000_0006); tick();
        flush = 1'b1;
        beat(1'b1, 3'd5, 32'h1000_0005);
        #1;
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_data", out_data, 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        beat(1'b0, 3'd0, 32'h0);
        chk("fl_empty_valid", 32'(out_valid), 32'd0);
        tick();
        chk("fl_empty_valid2", 32'(out_valid), 32'd0);

        // 5) N=5 instance: out-of-range selects give zero data
        in_valid5 = 1'b1; sel5 = 3'd6; tick();
        chk("n5_sel6_data", out_data5, 32'd0);
        chk("n5_sel6_valid", 32'(out_valid5), 32'd1);
        sel5 = 3'd4; tick();
        chk("n5_sel4_data", out_data5, 32'h5000_0004);
        sel5 = 3'd5; tick();
        chk("n5_sel5_data", out_data5, 32'd0);
        chk("n5_sel5_valid", 32'(out_valid5), 32'd1);
        in_valid5 = 1'b0; tick();
        chk("n5_idle_valid", 32'(out_valid5), 32'd0);
`ifdef MUX_SEL_ERR_EN
        chk("n5_sel_err_set", 32'(sel_err5), 32'd1);
        flush5 = 1'b1; tick(); flush5 = 1'b0;
        chk("n5_sel_err_flush", 32'(sel_err5), 32'd1);
        chk("n8_sel_err", 32'(sel_err8), 32'd0);
`endif
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("n5_rst_valid", 32'(out_valid5), 32'd0);
`ifdef MUX_SEL_ERR_EN
        chk("n5_sel_err_rst", 32'(sel_err5), 32'd0);
`endif

        // 6) random traffic with flushes and occasional reset
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < int'(N8); k++) in_bus[k*W +: W] = $urandom;
            sel       = 3'($urandom_range(0, 7));
            exp_cur   = in_bus[int'(sel)*W +: W];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
